// File: rtl/shift_pkg.sv
// Shared mode encodings, FSM state type and mode classification for univ_shift_reg.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Modes that may be repeated by the burst engine.
  function automatic logic is_shift_mode(input logic [2:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_ROR) ||
           (mode == MODE_ROL) || (mode == MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_next.sv
// Combinational next-value function of the universal register, shared by
// single-step and burst paths.
module shift_next
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             sin_l_i,
  input  logic             sin_r_i,
  output logic [WIDTH-1:0] next_q_o
);

  always_comb begin
    next_q_o = q_i;
    case (mode_i)
      MODE_HOLD: next_q_o = q_i;
      MODE_SHR:  next_q_o = {sin_l_i, q_i[WIDTH-1:1]};
      MODE_SHL:  next_q_o = {q_i[WIDTH-2:0], sin_r_i};
      MODE_ROR:  next_q_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_ROL:  next_q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_LOAD: next_q_o = d_i;
      MODE_ASR:  next_q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      MODE_CLR:  next_q_o = '0;
      default:   next_q_o = q_i;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with a single-step path and a Start/Busy/Done burst
// engine that repeats a latched shift-class operation Count times.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             sin_l_i,
  input  logic             sin_r_i,
  input  logic             start_i,
  input  logic [CW-1:0]    count_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_r_o,
  output logic             sout_l_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [CW-1:0] RemOne = {{(CW-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic [2:0]       step_mode;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    op_d      = op_q;
    done_d    = 1'b0;
    step_mode = MODE_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (start_i && is_shift_mode(mode_i)) begin
          // Start edge only arms the engine; Q holds until the first burst step.
          op_d  = mode_i;
          rem_d = count_i;
          if (count_i != '0) begin
            state_d = ST_BURST;
          end else begin
            done_d = 1'b1;
          end
        end else if (en_i) begin
          step_mode = mode_i;
        end
      end
      ST_BURST: begin
        step_mode = op_q;
        rem_d     = rem_q - RemOne;
        if (rem_q == RemOne) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  shift_next #(
    .WIDTH(WIDTH)
  ) u_shift_next (
    .q_i     (q_q),
    .mode_i  (step_mode),
    .d_i     (d_i),
    .sin_l_i (sin_l_i),
    .sin_r_i (sin_r_i),
    .next_q_o(q_d)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      op_q    <= MODE_HOLD;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign q_o      = q_q;
  assign sout_r_o = q_q[0];
  assign sout_l_o = q_q[WIDTH-1];
  assign busy_o   = (state_q == ST_BURST);
  assign done_o   = done_q;

endmodule
